// File: rtl/udma_hyper_arbiter.sv
// Round-robin arbiter that picks one uDMA channel request at a time and issues it to the
// HyperBus controller. A watchdog aborts any transfer the controller never completes.
module udma_hyper_arbiter #(
   parameter int unsigned  NB_CH       = 4,
   parameter int unsigned  NB_CS       = 2,
   parameter int unsigned  TRANS_SIZE  = 20,
   parameter int unsigned  TIMEOUT_CYC = 4096,
   localparam int unsigned CSW         = (NB_CS > 1) ? $clog2(NB_CS) : 1,
   localparam int unsigned IW          = (NB_CH > 1) ? $clog2(NB_CH) : 1,
   localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic                                sys_clk_i,
   input  logic                                rstn_i,

   input  logic [NB_CH-1:0]                    cfg_ch_en_i,
   input  logic [NB_CH-1:0]                    ch_req_i,
   input  logic [NB_CH-1:0][31:0]              ch_addr_i,
   input  logic [NB_CH-1:0][TRANS_SIZE-1:0]    ch_size_i,
   input  logic [NB_CH-1:0]                    ch_rwn_i,
   input  logic [NB_CH-1:0][CSW-1:0]           ch_cs_i,
   output logic [NB_CH-1:0]                    ch_gnt_o,

   output logic                                trans_valid_o,
   input  logic                                trans_ready_i,
   output logic [31:0]                         trans_addr_o,
   output logic [TRANS_SIZE-1:0]               trans_size_o,
   output logic                                trans_rwn_o,
   output logic [CSW-1:0]                      trans_cs_o,
   output logic [IW-1:0]                       trans_id_o,
   input  logic                                trans_done_i,
   output logic                                trans_abort_o,

   output logic [NB_CH-1:0]                    evt_eot_o,
   output logic [NB_CH-1:0]                    evt_err_o,
   output logic                                busy_o
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e                  state_q, state_d;
   logic [IW-1:0]           last_q, last_d;
   logic [IW-1:0]           owner_q, owner_d;
   logic [31:0]             addr_q, addr_d;
   logic [TRANS_SIZE-1:0]   size_q, size_d;
   logic                    rwn_q, rwn_d;
   logic [CSW-1:0]          cs_q, cs_d;
   logic [NB_CH-1:0]        gnt_q, gnt_d;
   logic [NB_CH-1:0]        eot_q, eot_d;
   logic [NB_CH-1:0]        err_q, err_d;
   logic                    abort_q, abort_d;
   logic [TW-1:0]           cnt_q, cnt_d;

   logic [NB_CH-1:0]        eligible;
   logic                    win_found;
   logic [IW-1:0]           win_idx;
   logic [IW-1:0]           cand;

   // Round-robin search starting just after the previous winner.
   always_comb begin
      eligible  = ch_req_i & cfg_ch_en_i;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= NB_CH; i++) begin
         cand = IW'((32'(last_q) + i) % NB_CH);
         if (!win_found && eligible[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      size_d  = size_q;
      rwn_d   = rwn_q;
      cs_d    = cs_q;
      cnt_d   = cnt_q;
      gnt_d   = '0;
      eot_d   = '0;
      err_d   = '0;
      abort_d = 1'b0;
      case (state_q)
         StIdle: begin
            // A grant pulse in flight means its requester still holds req this cycle.
            if (win_found && (gnt_q == '0)) begin
               last_d         = win_idx;
               owner_d        = win_idx;
               addr_d         = ch_addr_i[win_idx];
               size_d         = ch_size_i[win_idx];
               rwn_d          = ch_rwn_i[win_idx];
               cs_d           = ch_cs_i[win_idx];
               gnt_d[win_idx] = 1'b1;
               if (ch_size_i[win_idx] == '0) begin
                  eot_d[win_idx] = 1'b1;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            if (trans_ready_i) begin
               state_d = StWait;
               cnt_d   = '0;
            end
         end
         StWait: begin
            if (cnt_q != TW'(TIMEOUT_CYC)) begin
               cnt_d = cnt_q + TW'(1);
            end
            if (trans_done_i) begin
               eot_d[owner_q] = 1'b1;
               state_d        = StIdle;
            end else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
               err_d[owner_q] = 1'b1;
               abort_d        = 1'b1;
               state_d        = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= StIdle;
         last_q  <= IW'(NB_CH - 1);
         owner_q <= '0;
         addr_q  <= '0;
         size_q  <= '0;
         rwn_q   <= 1'b0;
         cs_q    <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         eot_q   <= '0;
         err_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         rwn_q   <= rwn_d;
         cs_q    <= cs_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         eot_q   <= eot_d;
         err_q   <= err_d;
         abort_q <= abort_d;
      end
   end

   assign ch_gnt_o      = gnt_q;
   assign trans_valid_o = (state_q == StIssue);
   assign trans_addr_o  = addr_q;
   assign trans_size_o  = size_q;
   assign trans_rwn_o   = rwn_q;
   assign trans_cs_o    = cs_q;
   assign trans_id_o    = owner_q;
   assign trans_abort_o = abort_q;
   assign evt_eot_o     = eot_q;
   assign evt_err_o     = err_q;
   assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_udma_hyper_arbiter.sv
// Bench for udma_hyper_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_udma_hyper_arbiter;

   localparam int NB_CH = 4;
   localparam int NB_CS = 2;
   localparam int TS    = 20;
   localparam int TO    = 16;
   localparam int CSW   = 1;
   localparam int IW    = 2;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic [NB_CH-1:0]           en, req, rwn;
   logic [NB_CH-1:0][31:0]     addr;
   logic [NB_CH-1:0][TS-1:0]   size;
   logic [NB_CH-1:0][CSW-1:0]  cs;
   logic                       ready, done;

   logic [NB_CH-1:0]  ch_gnt_o, evt_eot_o, evt_err_o;
   logic              trans_valid_o, trans_rwn_o, trans_abort_o, busy_o;
   logic [31:0]       trans_addr_o;
   logic [TS-1:0]     trans_size_o;
   logic [CSW-1:0]    trans_cs_o;
   logic [IW-1:0]     trans_id_o;

   always #5 clk = ~clk;

   udma_hyper_arbiter #(
      .NB_CH(NB_CH), .NB_CS(NB_CS), .TRANS_SIZE(TS), .TIMEOUT_CYC(TO)
   ) dut (
      .sys_clk_i(clk), .rstn_i(rstn),
      .cfg_ch_en_i(en), .ch_req_i(req), .ch_addr_i(addr), .ch_size_i(size),
      .ch_rwn_i(rwn), .ch_cs_i(cs), .ch_gnt_o(ch_gnt_o),
      .trans_valid_o(trans_valid_o), .trans_ready_i(ready), .trans_addr_o(trans_addr_o),
      .trans_size_o(trans_size_o), .trans_rwn_o(trans_rwn_o), .trans_cs_o(trans_cs_o),
      .trans_id_o(trans_id_o), .trans_done_i(done), .trans_abort_o(trans_abort_o),
      .evt_eot_o(evt_eot_o), .evt_err_o(evt_err_o), .busy_o(busy_o)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   // ---------------- reference model (transaction level) ----------------
   // phase: 0 = no transfer, 1 = offered to controller, 2 = controller working on it
   int          m_last, m_owner, m_phase, m_hs, cyc, w;
   logic [31:0] m_addr;
   logic [TS-1:0] m_size;
   logic        m_rwn;
   logic [CSW-1:0] m_cs;
   logic [NB_CH-1:0] e_gnt, e_eot, e_err, prev_gnt;
   logic        e_abort;

   function automatic int pick(input logic [NB_CH-1:0] elig, input int last);
      for (int k = 1; k <= NB_CH; k++) begin
         int c = (last + k) % NB_CH;
         if (elig[c]) return c;
      end
      return 0;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_last = NB_CH - 1; m_owner = 0; m_phase = 0; m_hs = 0; cyc = 0;
         m_addr = '0; m_size = '0; m_rwn = 1'b0; m_cs = '0;
         e_gnt = '0; e_eot = '0; e_err = '0; e_abort = 1'b0;
      end else begin
         cyc++;
         prev_gnt = e_gnt;
         e_gnt = '0; e_eot = '0; e_err = '0; e_abort = 1'b0;
         if (m_phase == 0) begin
            if (prev_gnt == '0 && (req & en) != '0) begin
               w = pick(req & en, m_last);
               m_last = w; m_owner = w;
               m_addr = addr[w]; m_size = size[w]; m_rwn = rwn[w]; m_cs = cs[w];
               e_gnt[w] = 1'b1;
               if (size[w] == '0) e_eot[w] = 1'b1;
               else m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (ready) begin
               m_phase = 2;
               m_hs    = cyc;
            end
         end else begin
            if (done) begin
               e_eot[m_owner] = 1'b1;
               m_phase = 0;
            end else if (cyc - m_hs == TO) begin
               e_err[m_owner] = 1'b1;
               e_abort = 1'b1;
               m_phase = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("cmp_gnt", ch_gnt_o, e_gnt);
      check("cmp_eot", evt_eot_o, e_eot);
      check("cmp_err", evt_err_o, e_err);
      check("cmp_abort", trans_abort_o, e_abort);
      check("cmp_valid", trans_valid_o, m_phase == 1);
      check("cmp_busy", busy_o, m_phase != 0);
      if (m_phase == 1 || !rstn) begin
         check("cmp_addr", trans_addr_o, m_addr);
         check("cmp_size", trans_size_o, m_size);
         check("cmp_rwn", trans_rwn_o, m_rwn);
         check("cmp_cs", trans_cs_o, m_cs);
         check("cmp_id", trans_id_o, m_owner);
      end
   end

   // ---------------- directed driver helpers ----------------
   int   wait_cnt   = 0;
   int   done_after = 0;
   logic auto_drop  = 1'b0;
   logic hs_seen    = 1'b0;

   task automatic run_cycle();
      logic hs;
      hs = trans_valid_o && ready;
      @(negedge clk); #1;
      if (hs) wait_cnt = 1;
      else if (wait_cnt > 0) wait_cnt++;
      hs_seen = hs;
      done = (done_after > 0) && (wait_cnt == done_after);
      if (auto_drop) req = req & ~ch_gnt_o;
   endtask

   task automatic drain();
      int k;
      req = '0; ready = 1'b1; done_after = 2; k = 0;
      while ((busy_o || ch_gnt_o != '0) && k < 100) begin
         run_cycle();
         k++;
      end
      check("drain_idle", busy_o, 1'b0);
      run_cycle();
      run_cycle();
   endtask

   int order[5];
   int eotcnt[NB_CH];
   int ngr, t, k;
   logic [NB_CH-1:0] gmask;
   logic any;

   initial begin
      en = '0; req = '0; rwn = '0; addr = '0; size = '0; cs = '0;
      ready = 1'b0; done = 1'b0;
      repeat (3) run_cycle();
      check("reset_busy", busy_o, 1'b0);
      check("reset_gnt", ch_gnt_o, 4'b0000);
      rstn = 1'b1;

      // Round-robin with every channel requesting continuously.
      en = 4'hF; req = 4'hF; ready = 1'b1; done_after = 3; auto_drop = 1'b0;
      for (int c = 0; c < NB_CH; c++) begin
         addr[c] = 32'h1000 * (c + 1); size[c] = TS'(8); rwn[c] = c[0]; cs[c] = c[1];
         eotcnt[c] = 0;
      end
      ngr = 0; k = 0;
      while (ngr < 5 && k < 80) begin
         run_cycle();
         k++;
         for (int c = 0; c < NB_CH; c++) begin
            if (evt_eot_o[c]) eotcnt[c]++;
            if (ch_gnt_o[c]) begin order[ngr] = c; ngr++; end
         end
      end
      check("rr_count", ngr, 5);
      check("rr_order0", order[0], 0);
      check("rr_order1", order[1], 1);
      check("rr_order2", order[2], 2);
      check("rr_order3", order[3], 3);
      check("rr_order4", order[4], 0);
      for (int c = 0; c < NB_CH; c++) check("rr_eot_once", eotcnt[c], 1);
      drain();

      // Single ch1 read with controller back-pressure.
      auto_drop = 1'b1; ready = 1'b0; done_after = 1;
      addr[1] = 32'hA5A5_0040; size[1] = TS'(20'h40); cs[1] = 1'b1; rwn[1] = 1'b1;
      req = 4'b0010; k = 0;
      while (ch_gnt_o == '0 && k < 20) begin run_cycle(); k++; end
      check("b_gnt", ch_gnt_o, 4'b0010);
      check("b_valid", trans_valid_o, 1'b1);
      check("b_rwn", trans_rwn_o, 1'b1);
      check("b_cs", trans_cs_o, 1'b1);
      check("b_id", trans_id_o, 2'd1);
      for (int i = 0; i < 5; i++) begin
         run_cycle();
         check("b_hold_valid", trans_valid_o, 1'b1);
         check("b_hold_addr", trans_addr_o, 32'hA5A5_0040);
         check("b_hold_size", trans_size_o, 20'h40);
      end
      ready = 1'b1;
      run_cycle();
      ready = 1'b0; k = 0;
      while (evt_eot_o == '0 && k < 10) begin run_cycle(); k++; end
      check("b_eot", evt_eot_o, 4'b0010);
      run_cycle();
      check("b_eot_once", evt_eot_o, 4'b0000);
      drain();

      // Watchdog timeout on ch3.
      auto_drop = 1'b1; ready = 1'b1; done_after = 0; size[3] = TS'(4); req = 4'b1000; k = 0;
      hs_seen = 1'b0;
      while (!hs_seen && k < 20) begin run_cycle(); k++; end
      t = 0;
      while (evt_err_o == '0 && t < 40) begin run_cycle(); t++; end
      check("to_latency", t, 16);
      check("to_err", evt_err_o, 4'b1000);
      check("to_abort", trans_abort_o, 1'b1);
      check("to_busy", busy_o, 1'b0);
      drain();

      // Done arrives on the exact timeout cycle.
      auto_drop = 1'b1; ready = 1'b1; done_after = 16; size[0] = TS'(4); req = 4'b0001; k = 0;
      hs_seen = 1'b0;
      while (!hs_seen && k < 20) begin run_cycle(); k++; end
      t = 0;
      while (evt_eot_o == '0 && evt_err_o == '0 && t < 40) begin run_cycle(); t++; end
      check("race_latency", t, 16);
      check("race_eot", evt_eot_o, 4'b0001);
      check("race_err", evt_err_o, 4'b0000);
      check("race_abort", trans_abort_o, 1'b0);
      drain();

      // Zero-size request on ch2.
      auto_drop = 1'b1; size[2] = '0; req = 4'b0100; k = 0;
      while (ch_gnt_o == '0 && k < 20) begin run_cycle(); k++; end
      check("z_gnt", ch_gnt_o, 4'b0100);
      check("z_eot", evt_eot_o, 4'b0100);
      any = trans_valid_o;
      for (int i = 0; i < 5; i++) begin run_cycle(); any = any | trans_valid_o; end
      check("z_never_valid", any, 1'b0);
      drain();

      // Masked channel never wins; reset in the middle of a transfer.
      en = 4'b1011; req = 4'hF; auto_drop = 1'b0; ready = 1'b1; done_after = 2;
      for (int c = 0; c < NB_CH; c++) size[c] = TS'(c + 1);
      gmask = '0;
      for (int i = 0; i < 40; i++) begin run_cycle(); gmask = gmask | ch_gnt_o; end
      check("mask_granted", gmask, 4'b1011);
      done_after = 0; k = 0;
      while (!(busy_o && !trans_valid_o) && k < 20) begin run_cycle(); k++; end
      check("rst_in_wait", busy_o, 1'b1);
      rstn = 1'b0;
      run_cycle();
      check("rst_busy", busy_o, 1'b0);
      check("rst_valid", trans_valid_o, 1'b0);
      check("rst_events", {ch_gnt_o, evt_eot_o, evt_err_o, trans_abort_o}, '0);
      req = '0; rstn = 1'b1; any = 1'b0;
      for (int i = 0; i < 4; i++) begin
         run_cycle();
         any = any | (|evt_eot_o) | (|evt_err_o) | trans_abort_o;
      end
      check("rst_silent", any, 1'b0);

      // Randomized traffic.
      en = 4'hF; ready = 1'b0; done = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk); #1;
         for (int c = 0; c < NB_CH; c++) begin
            if (req[c] && ch_gnt_o[c]) begin
               req[c] = 1'b0;
            end else if (!req[c] && $urandom_range(0, 3) == 0) begin
               req[c]  = 1'b1;
               addr[c] = $urandom;
               size[c] = ($urandom_range(0, 5) == 0) ? '0 : TS'($urandom_range(1, 1000));
               rwn[c]  = 1'($urandom);
               cs[c]   = 1'($urandom);
            end
         end
         ready = 1'($urandom_range(0, 1));
         done  = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 63) == 0) en[$urandom_range(0, 3)] ^= 1'b1;
         rstn = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      end
      rstn = 1'b1;
      run_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
